// File: rtl/fetch_addr_unit_pkg.sv
// Shared FSM encodings and constants for the fetch address engine.
// Imported by the top and the pc incrementer.
package fetch_addr_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } fetch_state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_addr_unit_pc_incr.sv
// Combinational next-word adder; wraps modulo 2^W.
// Also reused by the branch-target path.
module pc_incr
  import fetch_addr_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = a + W'(WORD_BYTES);

endmodule

// File: rtl/fetch_addr_unit.sv
// Instruction-fetch address engine: byte PC, word-indexed
// memory handshake and a one-entry output buffer for decode.
module fetch_addr_unit
  import fetch_addr_unit_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [DATA_WIDTH-1:0]  redirect_target,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [DATA_WIDTH-1:0]  imem_rdata,
  output logic                   if_valid,
  output logic [DATA_WIDTH-1:0]  if_instr,
  output logic [DATA_WIDTH-1:0]  if_pc,
  output logic [DATA_WIDTH-1:0]  if_pc_plus4,
  output logic                   misalign_err
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  take;

  pc_incr #(.W(DATA_WIDTH)) u_pc_incr (
    .a (pc),
    .y (pc_next)
  );

  // A held, stalled buffer or a pending redirect suppresses the request.
  assign imem_req = (state == S_REQ)
                  && !(if_valid && stall)
                  && !redirect_valid;

  assign imem_addr = pc[IMEM_ADDR_W+1:2];

  // Acks are only honoured while we are actually requesting.
  assign take = imem_ack && imem_req;

  // PC, FSM and output buffer; redirect has top priority after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= DATA_WIDTH'(RESET_PC);
      state        <= S_IDLE;
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      if_pc_plus4  <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if (is_misaligned(redirect_target[1:0])) begin
        state        <= S_ERR;
        misalign_err <= 1'b1;
      end else begin
        pc           <= redirect_target;
        state        <= S_REQ;
        misalign_err <= 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (take) begin
            if_instr    <= imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc_next;
            if_valid    <= 1'b1;
            pc          <= pc_next;
          end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
          end
        end
        S_ERR: state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
